inst_queue_nw: RTL and testbench

//  Slot-granular instruction queue between fetch and decode. Accepts one fetch group of FETCH_W

---
 rtl/inst_queue_nw_pkg.sv | 39 +++
 rtl/inst_queue_nw_fetch_compact.sv | 52 +++++
 rtl/inst_queue_nw.sv | 125 ++++++++++++
 tb/tb_inst_queue_nw.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_nw_pkg.sv
// Shared types, defaults and mask helpers for the slot-granular instruction queue.
package inst_queue_nw_pkg;

  // Default instruction and PC widths.
  localparam int INST_W_DEF  = 32;
  localparam int PC_W_DEF    = 32;

  // Widest fetch group the mask helpers handle; narrower groups are zero-extended.
  localparam int MAX_FETCH_W = 8;
  localparam int IDX_W       = $clog2(MAX_FETCH_W + 1);

  // One queue entry: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [INST_W_DEF-1:0] inst;
    logic [PC_W_DEF-1:0]   pc;
  } inst_slot_t;

  // Number of set bits in a (zero-extended) lane mask.
  function automatic logic [IDX_W-1:0] popcount(input logic [MAX_FETCH_W-1:0] m);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int b = 0; b < MAX_FETCH_W; b++) begin
      if (m[b]) c = c + IDX_W'(1);
    end
    return c;
  endfunction

  // Packed position of a lane: how many valid lanes sit below it.
  function automatic logic [IDX_W-1:0] compact_idx(input logic [MAX_FETCH_W-1:0] m,
                                                   input int lane);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int b = 0; b < MAX_FETCH_W; b++) begin
      if (b < lane && m[b]) c = c + IDX_W'(1);
    end
    return c;
  endfunction

endpackage

// File: rtl/inst_queue_nw_fetch_compact.sv
// Combinational packer: squeezes the valid lanes of a fetch group into consecutive
// slots (ascending lane order) and attaches each lane's PC.
module inst_queue_nw_fetch_compact
  import inst_queue_nw_pkg::*;
#(
  parameter int FETCH_W = 4,
  parameter int INST_W  = INST_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic [FETCH_W-1:0]            mask_i,
  input  logic [FETCH_W*INST_W-1:0]     inst_i,
  input  logic [PC_W-1:0]               pc_i,
  output logic [FETCH_W*INST_W-1:0]     slot_inst_o,
  output logic [FETCH_W*PC_W-1:0]       slot_pc_o,
  output logic [$clog2(FETCH_W+1)-1:0]  count_o
);

  localparam int K_W = $clog2(FETCH_W + 1);

  logic [MAX_FETCH_W-1:0] mask_ext;
  logic [PC_W-1:0]        lane_pc  [FETCH_W];
  logic [IDX_W-1:0]       lane_idx [FETCH_W];

  // Zero-extend the mask to the width the package helpers expect.
  always_comb begin
    mask_ext                = '0;
    mask_ext[FETCH_W-1:0]   = mask_i;
  end

  // Per-lane PC (4-byte instructions) and packed destination index.
  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
    assign lane_pc[gi]  = pc_i + PC_W'(4 * gi);
    assign lane_idx[gi] = compact_idx(mask_ext, gi);
  end

  // Route each valid lane to the output slot named by its packed index.
  always_comb begin
    slot_inst_o = '0;
    slot_pc_o   = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (mask_i[i] && lane_idx[i] == IDX_W'(j)) begin
          slot_inst_o[j*INST_W +: INST_W] = inst_i[i*INST_W +: INST_W];
          slot_pc_o[j*PC_W +: PC_W]       = lane_pc[i];
        end
      end
    end
  end

  assign count_o = K_W'(popcount(mask_ext));

endmodule

// File: rtl/inst_queue_nw.sv
// Instruction queue between fetch and decode: compacted enqueue of up to FETCH_W
// instructions per cycle, variable-count dequeue of up to DEC_W, single-cycle flush.
module inst_queue_nw
  import inst_queue_nw_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 4,
  parameter int DEC_W   = 2,
  parameter int INST_W  = INST_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic [FETCH_W*INST_W-1:0]     enq_inst,
  input  logic [FETCH_W-1:0]            enq_mask,
  input  logic [PC_W-1:0]               enq_pc,
  output logic [DEC_W*INST_W-1:0]       deq_inst,
  output logic [DEC_W*PC_W-1:0]         deq_pc,
  output logic [DEC_W-1:0]              deq_valid,
  input  logic [$clog2(DEC_W+1)-1:0]    deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(DEC_W + 1);
  localparam int K_W   = $clog2(FETCH_W + 1);

  // Slot storage; not reset, validity is tracked by occupancy alone.
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q,  occ_d;

  logic [FETCH_W*INST_W-1:0] pk_inst;
  logic [FETCH_W*PC_W-1:0]   pk_pc;
  logic [K_W-1:0]            pk_cnt;

  logic             enq_fire;
  logic [K_W-1:0]   k_eff;
  logic [OCC_W-1:0] deq_req;
  logic [OCC_W-1:0] eff;

  inst_queue_nw_fetch_compact #(
    .FETCH_W (FETCH_W),
    .INST_W  (INST_W),
    .PC_W    (PC_W)
  ) u_compact (
    .mask_i      (enq_mask),
    .inst_i      (enq_inst),
    .pc_i        (enq_pc),
    .slot_inst_o (pk_inst),
    .slot_pc_o   (pk_pc),
    .count_o     (pk_cnt)
  );

  // Room for a whole group is required regardless of how sparse the mask is,
  // so readiness depends only on registered state.
  assign enq_ready = (occ_q <= OCC_W'(DEPTH - FETCH_W));
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign k_eff     = enq_fire ? pk_cnt : '0;

  // Clamp the decode consume count to what is actually held.
  assign deq_req = OCC_W'(deq_cnt);
  assign eff     = (deq_req > occ_q) ? occ_q : deq_req;

  // Next-state pointers and occupancy; flush empties the queue outright.
  always_comb begin
    head_d = head_q + PTR_W'(eff);
    tail_d = tail_q + PTR_W'(k_eff);
    occ_d  = occ_q + OCC_W'(k_eff) - eff;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  // Pointer and occupancy registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Write the packed group at tail, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (j < int'(pk_cnt)) begin
          inst_mem[tail_q + PTR_W'(j)] <= pk_inst[j*INST_W +: INST_W];
          pc_mem[tail_q + PTR_W'(j)]   <= pk_pc[j*PC_W +: PC_W];
        end
      end
    end
  end

  // Decode must never ask for more than DEC_W instructions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (deq_cnt <= CNT_W'(DEC_W));
    end
  end

  // Present the oldest DEC_W slots; lanes beyond occupancy carry stale data.
  for (genvar gi = 0; gi < DEC_W; gi++) begin : g_deq
    assign deq_inst[gi*INST_W +: INST_W] = inst_mem[head_q + PTR_W'(gi)];
    assign deq_pc[gi*PC_W +: PC_W]       = pc_mem[head_q + PTR_W'(gi)];
    assign deq_valid[gi]                 = (occ_q > OCC_W'(gi));
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_inst_queue_nw.sv
// Directed bench for inst_queue_nw: reset, compaction, fill/full, wrap,
// dequeue clamping, flush and reset-with-flush.
module tb_inst_queue_nw;

  localparam int FETCH_W = 4;
  localparam int DEC_W   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         enq_valid;
  logic         enq_ready;
  logic [127:0] enq_inst;
  logic [3:0]   enq_mask;
  logic [31:0]  enq_pc;
  logic [63:0]  deq_inst;
  logic [63:0]  deq_pc;
  logic [1:0]   deq_valid;
  logic [1:0]   deq_cnt;
  logic [4:0]   occupancy;

  int passed = 0;
  int total  = 0;

  inst_queue_nw dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_inst  (enq_inst),
    .enq_mask  (enq_mask),
    .enq_pc    (enq_pc),
    .deq_inst  (deq_inst),
    .deq_pc    (deq_pc),
    .deq_valid (deq_valid),
    .deq_cnt   (deq_cnt),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Instruction word derived from its PC so each lane is distinguishable.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_lane(input string tag, input int lane, input logic [31:0] exp_pc);
    check({tag, "_pc"},   deq_pc[lane*32 +: 32],   exp_pc);
    check({tag, "_inst"}, deq_inst[lane*32 +: 32], inst_of(exp_pc));
  endtask

  // Drive one cycle of fetch/decode stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] m, input logic [31:0] pc,
                      input logic [1:0] dc);
    enq_valid = v;
    enq_mask  = m;
    enq_pc    = pc;
    deq_cnt   = dc;
    for (int i = 0; i < FETCH_W; i++) enq_inst[i*32 +: 32] = inst_of(pc + 32'(4 * i));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_mask = '0;
    enq_pc = '0; enq_inst = '0; deq_cnt = '0;

    // Reset
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_valid", 32'(deq_valid), 32'd0);
    check("rst_ready", 32'(enq_ready), 32'd1);

    // Full group
    step(1'b1, 4'b1111, 32'h1000, 2'd0);
    check("full_occ",   32'(occupancy), 32'd4);
    check("full_valid", 32'(deq_valid), 32'd3);
    check_lane("full_l0", 0, 32'h1000);
    check_lane("full_l1", 1, 32'h1004);
    step(1'b0, 4'b0000, 32'h0, 2'd2);
    check("drain_occ", 32'(occupancy), 32'd2);
    check_lane("drain_l0", 0, 32'h1008);
    step(1'b0, 4'b0000, 32'h0, 2'd2);
    check("empty_valid", 32'(deq_valid), 32'd0);

    // Sparse mask compaction
    step(1'b1, 4'b1010, 32'h2000, 2'd0);
    check("sparse_occ", 32'(occupancy), 32'd2);
    check_lane("sparse_l0", 0, 32'h2004);
    check_lane("sparse_l1", 1, 32'h200C);
    step(1'b1, 4'b0000, 32'h2100, 2'd0);
    check("k0_occ", 32'(occupancy), 32'd2);

    // Fill to 13 with a group that straddles slot 15 -> 0
    step(1'b1, 4'b1111, 32'h3000, 2'd0);
    check("fill6_occ", 32'(occupancy), 32'd6);
    step(1'b1, 4'b1111, 32'h3010, 2'd0);
    check("fill10_occ", 32'(occupancy), 32'd10);
    check("fill10_rdy", 32'(enq_ready), 32'd1);
    step(1'b1, 4'b1011, 32'h3020, 2'd0);
    check("fill13_occ", 32'(occupancy), 32'd13);
    check("fill13_rdy", 32'(enq_ready), 32'd0);
    step(1'b1, 4'b1111, 32'h4000, 2'd0);
    check("reject_occ", 32'(occupancy), 32'd13);

    // Walk head to 14, then dequeue across the wrap
    repeat (5) step(1'b0, 4'b0000, 32'h0, 2'd2);
    check("head14_occ", 32'(occupancy), 32'd3);
    check_lane("h14_l0", 0, 32'h3020);
    check_lane("h14_l1", 1, 32'h3024);
    step(1'b1, 4'b1111, 32'h5000, 2'd2);
    check("wrap_occ", 32'(occupancy), 32'd5);
    check_lane("wrap_l0", 0, 32'h302C);
    check_lane("wrap_l1", 1, 32'h5000);
    step(1'b0, 4'b0000, 32'h0, 2'd2);
    check_lane("post_l0", 0, 32'h5004);
    check_lane("post_l1", 1, 32'h5008);

    // Readiness boundary at DEPTH-FETCH_W
    step(1'b1, 4'b1111, 32'h6000, 2'd0);
    step(1'b1, 4'b1111, 32'h6010, 2'd0);
    step(1'b1, 4'b0001, 32'h6020, 2'd0);
    check("b12_occ", 32'(occupancy), 32'd12);
    check("b12_rdy", 32'(enq_ready), 32'd1);
    step(1'b1, 4'b1000, 32'h7000, 2'd0);
    check("b13_occ", 32'(occupancy), 32'd13);
    check("b13_rdy", 32'(enq_ready), 32'd0);
    repeat (6) step(1'b0, 4'b0000, 32'h0, 2'd2);
    check("one_occ",   32'(occupancy), 32'd1);
    check("one_valid", 32'(deq_valid), 32'd1);
    check_lane("one_l0", 0, 32'h700C);

    // Clamped dequeue with same-cycle enqueue, then underflow attempts
    step(1'b1, 4'b0011, 32'h8000, 2'd2);
    check("clamp_occ", 32'(occupancy), 32'd2);
    check_lane("clamp_l0", 0, 32'h8000);
    check_lane("clamp_l1", 1, 32'h8004);
    step(1'b0, 4'b0000, 32'h0, 2'd2);
    check("drain2_occ", 32'(occupancy), 32'd0);
    step(1'b0, 4'b0000, 32'h0, 2'd2);
    check("under_occ",   32'(occupancy), 32'd0);
    check("under_valid", 32'(deq_valid), 32'd0);

    // Flush with a group offered
    step(1'b1, 4'b1111, 32'h9000, 2'd0);
    step(1'b1, 4'b1111, 32'h9010, 2'd0);
    step(1'b1, 4'b0011, 32'h9020, 2'd0);
    check("pre_fl_occ", 32'(occupancy), 32'd10);
    flush = 1'b1;
    step(1'b1, 4'b1111, 32'hA000, 2'd2);
    flush = 1'b0;
    check("flush_occ",   32'(occupancy), 32'd0);
    check("flush_valid", 32'(deq_valid), 32'd0);
    check("flush_rdy",   32'(enq_ready), 32'd1);
    step(1'b0, 4'b0000, 32'h0, 2'd0);
    check("dropped_occ", 32'(occupancy), 32'd0);
    step(1'b1, 4'b0001, 32'hB000, 2'd0);
    check("postfl_occ", 32'(occupancy), 32'd1);
    check_lane("postfl_l0", 0, 32'hB000);

    // Reset together with flush and an offered group
    rst = 1'b1; flush = 1'b1;
    step(1'b1, 4'b1111, 32'hC000, 2'd0);
    check("rstfl_occ",   32'(occupancy), 32'd0);
    check("rstfl_valid", 32'(deq_valid), 32'd0);
    check("rstfl_rdy",   32'(enq_ready), 32'd1);
    rst = 1'b0; flush = 1'b0;
    step(1'b1, 4'b1111, 32'hD000, 2'd0);
    check("after_occ", 32'(occupancy), 32'd4);
    check_lane("after_l0", 0, 32'hD000);
    check_lane("after_l1", 1, 32'hD004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
